// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, FSM encoding and the RGB565 colour palette
// for the bouncing character block.
package vga_pkg;

    localparam logic [9:0] H_VALID = 10'd640;
    localparam logic [9:0] V_VALID = 10'd480;
    localparam logic [9:0] CHAR_W  = 10'd256;
    localparam logic [9:0] CHAR_H  = 10'd64;

    localparam logic       DIR_POS = 1'b1;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_ORANGE  = 16'hFEC0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    function automatic logic [15:0] palette(input logic [2:0] idx);
        logic [15:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_RED;
            3'd2:    col = COL_GREEN;
            3'd3:    col = COL_BLUE;
            3'd4:    col = COL_YELLOW;
            3'd5:    col = COL_CYAN;
            3'd6:    col = COL_MAGENTA;
            default: col = COL_ORANGE;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/vga_axis_bounce.sv
// One axis of block motion: step toward the current direction, clamp at 0/max,
// flip direction and flag a hit when a wall is reached. Purely combinational.
module vga_axis_bounce (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [9:0] step,
    input  logic [9:0] max,
    input  logic       load,
    output logic [9:0] pos_nxt,
    output logic       dir_nxt,
    output logic       hit
);

    logic [10:0] sum;

    // 11-bit sum so a position near 1023 plus the step cannot wrap past max
    assign sum = {1'b0, pos} + {1'b0, step};

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        hit     = 1'b0;
        if (load) begin
            if (dir) begin
                if (sum >= {1'b0, max}) begin
                    pos_nxt = max;
                    dir_nxt = ~dir;
                    hit     = 1'b1;
                end else begin
                    pos_nxt = sum[9:0];
                end
            end else begin
                if ({1'b0, pos} <= {1'b0, step}) begin
                    pos_nxt = 10'd0;
                    dir_nxt = ~dir;
                    hit     = 1'b1;
                end else begin
                    pos_nxt = pos - step;
                end
            end
        end
    end

endmodule

// File: rtl/vga_char_mover.sv
// Moves a character block around the visible area once every FRAME_DIV frames,
// bouncing off the edges and cycling the foreground colour on each wall hit.
module vga_char_mover #(
    parameter logic [9:0] H_VALID   = vga_pkg::H_VALID,
    parameter logic [9:0] V_VALID   = vga_pkg::V_VALID,
    parameter logic [9:0] CHAR_W    = vga_pkg::CHAR_W,
    parameter logic [9:0] CHAR_H    = vga_pkg::CHAR_H,
    parameter logic [9:0] INIT_H    = 10'd192,
    parameter logic [9:0] INIT_V    = 10'd208,
    parameter logic [9:0] STEP_X    = 10'd2,
    parameter logic [9:0] STEP_Y    = 10'd1,
    parameter logic [3:0] FRAME_DIV = 4'd1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        en,
    input  logic        recenter,
    output logic [9:0]  char_b_h,
    output logic [9:0]  char_b_v,
    output logic [15:0] char_color,
    output logic        bounce,
    output logic        corner
);

    localparam logic [9:0] X_MAX = H_VALID - CHAR_W;
    localparam logic [9:0] Y_MAX = V_VALID - CHAR_H;

    vga_pkg::state_e state_q, state_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  pix_y_d1_q, pix_y_d1_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] color_q, color_d;
    logic        bounce_q, bounce_d, corner_q, corner_d;

    logic        frame_end, load;
    logic [9:0]  h_nxt, v_nxt;
    logic        dir_x_nxt, dir_y_nxt, hit_x, hit_y;
    logic        unused_pix_x;

    assign unused_pix_x = ^pix_x;

    // Falling edge of the last visible line marks the start of vertical blanking
    assign frame_end = (pix_y_d1_q == V_VALID - 10'd1) && (pix_y != V_VALID - 10'd1);
    assign load      = (state_q == vga_pkg::ST_UPDATE);

    vga_axis_bounce u_axis_x (
        .pos     (h_q),
        .dir     (dir_x_q),
        .step    (STEP_X),
        .max     (X_MAX),
        .load    (load),
        .pos_nxt (h_nxt),
        .dir_nxt (dir_x_nxt),
        .hit     (hit_x)
    );

    vga_axis_bounce u_axis_y (
        .pos     (v_q),
        .dir     (dir_y_q),
        .step    (STEP_Y),
        .max     (Y_MAX),
        .load    (load),
        .pos_nxt (v_nxt),
        .dir_nxt (dir_y_nxt),
        .hit     (hit_y)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pix_y_d1_d  = pix_y;
        case (state_q)
            vga_pkg::ST_IDLE: begin
                frame_cnt_d = 4'd0;
                if (en) state_d = vga_pkg::ST_WAIT;
            end
            vga_pkg::ST_WAIT: begin
                if (!en) begin
                    state_d     = vga_pkg::ST_IDLE;
                    frame_cnt_d = 4'd0;
                end else if (frame_end) begin
                    if (frame_cnt_q == FRAME_DIV - 4'd1) begin
                        state_d     = vga_pkg::ST_UPDATE;
                        frame_cnt_d = 4'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            vga_pkg::ST_UPDATE: state_d = vga_pkg::ST_WAIT;
            default:            state_d = vga_pkg::ST_IDLE;
        endcase
    end

    // Recenter wins over a coincident update; the FSM itself is left alone
    always_comb begin
        h_d      = h_nxt;
        v_d      = v_nxt;
        dir_x_d  = dir_x_nxt;
        dir_y_d  = dir_y_nxt;
        bounce_d = hit_x | hit_y;
        corner_d = hit_x & hit_y;
        idx_d    = idx_q + {2'b00, (hit_x | hit_y)};
        if (recenter) begin
            h_d      = INIT_H;
            v_d      = INIT_V;
            dir_x_d  = vga_pkg::DIR_POS;
            dir_y_d  = vga_pkg::DIR_POS;
            bounce_d = 1'b0;
            corner_d = 1'b0;
            idx_d    = 3'd0;
        end
        color_d = vga_pkg::palette(idx_d);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q     <= vga_pkg::ST_IDLE;
            frame_cnt_q <= 4'd0;
            pix_y_d1_q  <= 10'h3FF;
            h_q         <= INIT_H;
            v_q         <= INIT_V;
            dir_x_q     <= vga_pkg::DIR_POS;
            dir_y_q     <= vga_pkg::DIR_POS;
            idx_q       <= 3'd0;
            color_q     <= vga_pkg::COL_WHITE;
            bounce_q    <= 1'b0;
            corner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pix_y_d1_q  <= pix_y_d1_d;
            h_q         <= h_d;
            v_q         <= v_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            idx_q       <= idx_d;
            color_q     <= color_d;
            bounce_q    <= bounce_d;
            corner_q    <= corner_d;
        end
    end

    assign char_b_h   = h_q;
    assign char_b_v   = v_q;
    assign char_color = color_q;
    assign bounce     = bounce_q;
    assign corner     = corner_q;

endmodule

// File: tb/tb_vga_char_mover.sv
// Directed bench: default mover, a mover starting one step from the corner,
// and a mover updating every third frame, all sharing one stimulus stream.
module tb_vga_char_mover;

    logic        clk = 1'b0;
    logic        sys_rst, en, recenter;
    logic [9:0]  pix_x, pix_y;

    logic [9:0]  h0, v0, hc, vc, h3, v3;
    logic [15:0] col0, colc, col3;
    logic        b0, c0, bc, cc, b3, c3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_char_mover dut (
        .vga_clk(clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .en(en), .recenter(recenter), .char_b_h(h0), .char_b_v(v0),
        .char_color(col0), .bounce(b0), .corner(c0)
    );

    vga_char_mover #(.INIT_H(10'd382), .INIT_V(10'd415)) dut_c (
        .vga_clk(clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .en(en), .recenter(recenter), .char_b_h(hc), .char_b_v(vc),
        .char_color(colc), .bounce(bc), .corner(cc)
    );

    vga_char_mover #(.FRAME_DIV(4'd3)) dut_3 (
        .vga_clk(clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .en(en), .recenter(recenter), .char_b_h(h3), .char_b_v(v3),
        .char_color(col3), .bounce(b3), .corner(c3)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Last visible line then blanking; leaves the bench on the cycle after UPDATE
    task automatic frame();
        pix_y = 10'd479;
        cyc();
        pix_y = 10'h3FF;
        cyc();
        cyc();
    endtask

    initial begin
        sys_rst  = 1'b1;
        en       = 1'b0;
        recenter = 1'b0;
        pix_x    = 10'h3FF;
        pix_y    = 10'h3FF;
        cyc();
        cyc();
        sys_rst = 1'b0;
        chk("rst_h", h0, 10'd192);
        chk("rst_v", v0, 10'd208);
        chk("rst_col", col0, 16'hFFFF);
        chk("rst_bounce", b0, 1'b0);
        chk("rst_corner", c0, 1'b0);

        en = 1'b1;
        cyc();
        pix_y = 10'd479;
        cyc();
        pix_y = 10'h3FF;
        cyc();
        chk("lat_early_h", h0, 10'd192);
        cyc();
        chk("lat_h", h0, 10'd194);
        chk("lat_v", v0, 10'd209);
        chk("lat_bounce", b0, 1'b0);
        chk("div3_f1_h", h3, 10'd192);
        chk("corner_h", hc, 10'd384);
        chk("corner_v", vc, 10'd416);
        chk("corner_bounce", bc, 1'b1);
        chk("corner_flag", cc, 1'b1);
        chk("corner_col", colc, 16'hF800);

        frame();
        chk("corner_back_h", hc, 10'd382);
        chk("corner_back_v", vc, 10'd415);
        chk("corner_back_bounce", bc, 1'b0);
        chk("corner_back_col", colc, 16'hF800);
        chk("div3_f2_h", h3, 10'd192);
        chk("mv2_h", h0, 10'd196);

        frame();
        chk("div3_f3_h", h3, 10'd194);
        chk("div3_f3_v", v3, 10'd209);
        chk("mv3_h", h0, 10'd198);

        for (int i = 0; i < 92; i++) frame();
        chk("pre_wall_h", h0, 10'd382);
        chk("pre_wall_v", v0, 10'd303);
        chk("pre_wall_bounce", b0, 1'b0);
        chk("pre_wall_col", col0, 16'hFFFF);

        frame();
        chk("wall_h", h0, 10'd384);
        chk("wall_v", v0, 10'd304);
        chk("wall_bounce", b0, 1'b1);
        chk("wall_corner", c0, 1'b0);
        chk("wall_col", col0, 16'hF800);
        cyc();
        chk("wall_pulse_end", b0, 1'b0);

        frame();
        chk("after_wall_h", h0, 10'd382);
        chk("after_wall_v", v0, 10'd305);
        chk("after_wall_col", col0, 16'hF800);

        en = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) frame();
        chk("freeze_h", h0, 10'd382);
        chk("freeze_v", v0, 10'd305);

        en = 1'b1;
        cyc();
        pix_y = 10'd479;
        cyc();
        pix_y = 10'h3FF;
        cyc();
        recenter = 1'b1;
        cyc();
        recenter = 1'b0;
        chk("recenter_h", h0, 10'd192);
        chk("recenter_v", v0, 10'd208);
        chk("recenter_col", col0, 16'hFFFF);
        chk("recenter_bounce", b0, 1'b0);

        frame();
        chk("post_recenter_h", h0, 10'd194);
        chk("post_recenter_v", v0, 10'd209);

        pix_y = 10'd479;
        cyc();
        pix_y = 10'h3FF;
        cyc();
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
        chk("rst_upd_h", h0, 10'd192);
        chk("rst_upd_v", v0, 10'd208);
        chk("rst_upd_col", col0, 16'hFFFF);
        chk("rst_upd_c_col", colc, 16'hFFFF);
        chk("rst_upd_c_h", hc, 10'd382);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
